// File: rtl/scanner_pkg.sv
// Shared widths, ZBT word layout and writer state encoding for the point-cloud writer.
// A ZBT data word is {5'b0, valid, x, y, z}; the all-zero word terminates a scan.
package scanner_pkg;

    localparam int POINT_W    = 10;
    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;
    localparam int PT_W       = 3 * POINT_W;

    localparam int Z_LSB     = 0;
    localparam int Y_LSB     = 10;
    localparam int X_LSB     = 20;
    localparam int VALID_LSB = 30;

    localparam logic [ZBT_DATA_W-1:0] TERMINATOR_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FLUSH,
        ST_TERM
    } writer_state_e;

    // pt is the FIFO entry {x, y, z}, which already sits at the word's low 30 bits
    function automatic logic [ZBT_DATA_W-1:0] pack_point(input logic [PT_W-1:0] pt);
        logic [ZBT_DATA_W-1:0] w;
        w                  = '0;
        w[VALID_LSB]       = 1'b1;
        w[VALID_LSB-1:0]   = pt;
        return w;
    endfunction

endpackage

// File: rtl/point_fifo.sv
// Synchronous point FIFO with clear; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module point_fifo
    import scanner_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [PT_W-1:0] wr_data,
    output logic [PT_W-1:0] rd_data,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = 'd1;

    logic [PT_W-1:0] mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        pop_ok   = pop && !empty;
        // a push into a full FIFO is fine when the same cycle frees a slot
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_INC;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_INC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid,
    // and leaving the array unreset lets it map onto plain RAM/register files.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/point_cloud_writer.sv
// Buffers scan points and writes them to ZBT0 in arbiter-granted slots at sequential
// addresses from 0, then appends a terminator word when the scan is done.
module point_cloud_writer
    import scanner_pkg::*;
#(
    parameter logic [ZBT_ADDR_W-1:0] MAX_POINTS = 19'd524287,
    parameter int                    FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  scan_start,
    input  logic                  scan_done,
    input  logic                  pt_valid,
    output logic                  pt_ready,
    input  logic [POINT_W-1:0]    pt_x,
    input  logic [POINT_W-1:0]    pt_y,
    input  logic [POINT_W-1:0]    pt_z,
    input  logic                  zbt_write_slot,
    output logic                  zbt0_we,
    output logic [ZBT_ADDR_W-1:0] zbt0_write_addr,
    output logic [ZBT_DATA_W-1:0] zbt0_write_data,
    output logic [ZBT_ADDR_W-1:0] point_count,
    output logic                  overflow,
    output logic                  busy,
    output logic                  scan_complete
);

    localparam logic [ZBT_ADDR_W-1:0] ADDR_INC = 'd1;

    writer_state_e         state_q, state_d;
    logic                  we_q, we_d;
    logic [ZBT_ADDR_W-1:0] addr_q, addr_d;
    logic [ZBT_DATA_W-1:0] data_q, data_d;
    logic [ZBT_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ZBT_ADDR_W-1:0] accepted_q, accepted_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, busy_d;
    logic                  scan_complete_q, scan_complete_d;

    logic                  xfer, hit, at_capacity;
    logic                  fifo_push, fifo_pop, fifo_clear;
    logic                  fifo_full, fifo_empty;
    logic [PT_W-1:0]       fifo_rd_data;

    point_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (fifo_clear),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({pt_x, pt_y, pt_z}),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pt_ready    = (state_q == ST_CAPTURE) && !fifo_full;
    assign xfer        = pt_valid && pt_ready;
    assign hit         = (pt_z != '0);
    // Capacity is reserved at accept time so the FIFO never holds a point that cannot be written
    assign at_capacity = (accepted_q == MAX_POINTS);

    // NOTE: next-state logic is purely combinational with a default for every output
    // first, so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        we_d            = 1'b0;
        addr_d          = addr_q;
        data_d          = data_q;
        wr_addr_d       = wr_addr_q;
        accepted_d      = accepted_q;
        overflow_d      = overflow_q;
        scan_complete_d = 1'b0;
        fifo_clear      = 1'b0;
        fifo_pop        = 1'b0;
        fifo_push       = xfer && hit && !at_capacity;

        if (fifo_push)                   accepted_d = accepted_q + ADDR_INC;
        if (xfer && hit && at_capacity)  overflow_d = 1'b1;

        if (scan_start) begin
            // a write already registered still appears on the bus; nothing new is popped
            state_d    = ST_CAPTURE;
            fifo_clear = 1'b1;
            wr_addr_d  = '0;
            accepted_d = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_CAPTURE, ST_FLUSH: begin
                    if (zbt_write_slot && !fifo_empty) begin
                        fifo_pop  = 1'b1;
                        we_d      = 1'b1;
                        addr_d    = wr_addr_q;
                        data_d    = pack_point(fifo_rd_data);
                        wr_addr_d = wr_addr_q + ADDR_INC;
                    end
                    if (state_q == ST_CAPTURE && scan_done) state_d = ST_FLUSH;
                    if (state_q == ST_FLUSH && fifo_empty && !we_q) state_d = ST_TERM;
                end
                ST_TERM: begin
                    if (zbt_write_slot) begin
                        we_d            = 1'b1;
                        addr_d          = wr_addr_q;
                        data_d          = TERMINATOR_WORD;
                        scan_complete_d = 1'b1;
                        state_d         = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            we_q            <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            wr_addr_q       <= '0;
            accepted_q      <= '0;
            overflow_q      <= 1'b0;
            busy_q          <= 1'b0;
            scan_complete_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            wr_addr_q       <= wr_addr_d;
            accepted_q      <= accepted_d;
            overflow_q      <= overflow_d;
            busy_q          <= busy_d;
            scan_complete_q <= scan_complete_d;
        end
    end

    assign zbt0_we         = we_q;
    assign zbt0_write_addr = addr_q;
    assign zbt0_write_data = data_q;
    assign point_count     = wr_addr_q;
    assign overflow        = overflow_q;
    assign busy            = busy_q;
    assign scan_complete   = scan_complete_q;

endmodule
